command_sequencer: RTL and testbench
====================================

# command_sequencer

Parametrised front-panel command engine for the system bus. It captures operator command words from `switch1` on `button1`, queues them in a DEPTH-entry FIFO, and on `button2` drains the whole queue. Each command is serialized MSB-first, LANE_W bits per cycle, onto either the shared write lane or the read lane of the addressed master channel. `button3` aborts and flushes. It sits between the board switches/buttons and the bus master command inputs.

## Interface
- SW_W, 8: command word width; must be a multiple of LANE_W and ≥ 2+CH_W.
- LANE_W, 2: serial lane width in bits.
- N_CH, 2: number of master read channels; CH_W = max(1, clog2(N_CH)).
- DEPTH, 4: FIFO entries (power of two).
- GAP_CYC, 2: idle cycles between consecutive commands (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- switch1  in  SW_W  command word; sampled on the cycle a button1 rise is detected.
- button1  in  1  capture (push) request, rising-edge detected.
- button2  in  1  run request, rising-edge detected.
- button3  in  1  abort/flush request, rising-edge detected.
- data_read  out  N_CH*LANE_W  per-channel read lanes; channel c occupies [c*LANE_W +: LANE_W].
- data_write  out  LANE_W  shared write lane.
- valid_read  out  N_CH  per-channel symbol valid.
- valid_write  out  1  write lane symbol valid.
- busy  out  1  high in any state other than IDLE.
- fifo_count  out  clog2(DEPTH)+1  queued commands.
- overflow  out  1  sticky: push attempted while full.
- bad_ch  out  1  sticky: command with channel index ≥ N_CH dropped.

## Operation
- Command word fields: bit SW_W-1 = op (1 write, 0 read); bits [SW_W-2 -: CH_W] = channel (reads only, ignored for writes); the whole word is transmitted.
- Button edge detect: one registered copy per button; rise = btn & ~btn_q. A held button acts once. All register state resets to 0.
- Push: on a button1 rise, if count<DEPTH or a pop occurs the same cycle, switch1 is written to the FIFO; otherwise the word is discarded and overflow is set.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE → LOAD on a button2 rise with count>0. A button2 rise with an empty FIFO, or outside IDLE, is ignored.
- LOAD: pop the head into the shift register and load the symbol counter with NSYM = SW_W/LANE_W.
  - Read with channel ≥ N_CH: set bad_ch, emit nothing, go to GAP.
  - Otherwise go to SHIFT.
- SHIFT: drive the top LANE_W bits onto the selected lane with its valid high. Shift left by LANE_W each cycle. After NSYM symbols go to GAP.
- GAP: lanes are 0 and valids are 0 for GAP_CYC cycles. Then go to LOAD if count>0, else IDLE.
- Words pushed during a run are drained in the same run if they are present when GAP exits.
- Abort: a button3 rise in any state empties the FIFO, forces IDLE and zeroes lanes/valids next cycle. overflow and bad_ch are kept.
  - button3 has priority over button1/button2 rises in the same cycle; such a push is dropped and not flagged.
- Non-selected lanes are held at 0 at all times; at most one valid is high.
- Mid-operation reset: outputs clear immediately (asynchronous) and the FIFO is empty.

## Timing
- Reset values: data_read=0, data_write=0, valid_read=0, valid_write=0, busy=0, fifo_count=0, overflow=0, bad_ch=0.
- All outputs are registered.
- A button1 rise sampled at edge t gives fifo_count updated after t+1.
- A button2 rise sampled at edge t (IDLE) gives busy=1 after t+1 (LOAD), first symbol valid after t+2, last symbol after t+1+NSYM.
- Command-to-command spacing: NSYM + GAP_CYC + 1 (LOAD) cycles.
- Abort sampled at edge t gives lanes, valids and busy all 0 after t+1.

## Configuration
- CMD_PARITY_EN defined: after the NSYM data symbols, one extra symbol {LANE_W-1 zeros, ^word} (even parity) is sent on the same lane with valid high. NSYM becomes SW_W/LANE_W+1, and all latencies shift by 1.
- CMD_PARITY_EN undefined: no parity symbol; NSYM = SW_W/LANE_W.

## Test plan
Defaults for all scenarios, macro off.
- Push 8'b10101010, then button2 → data_write = 10,10,10,10 on 4 consecutive cycles with valid_write high, first symbol 2 cycles after the button2 sample; busy low after GAP.
- Push 8'b01100010 and 8'b11100010, then button2 → valid_read[1] with 01,10,00,10; 3 idle cycles (2 GAP + 1 LOAD); then data_write = 11,10,00,10. data_read[1:0] stays 0 throughout.
- Push 5 words with DEPTH=4 → fifo_count=4 and overflow=1; the run emits only the first 4.
- With N_CH=3, push 8'b01100000 (channel 3) then button2 → bad_ch=1, no valid asserted, busy returns low after GAP.
- Mid-SHIFT button3 with 2 words queued → valids/lanes/busy 0 next cycle, fifo_count=0; a subsequent button2 is ignored. Async reset mid-run clears all outputs without a clock edge.
- CMD_PARITY_EN, push 8'b10101010 → symbols 10,10,10,10,00 (parity 0); push 8'b11100010 → final symbol 00 (4 ones → parity 0); push 8'b10000000 → final symbol 01.

Source files
------------

// File: rtl/command_sequencer_if.sv
// command_sequencer_if: front-panel inputs and serial bus-command outputs of command_sequencer.
// master = panel/driver side, slave = sequencer side.
interface command_sequencer_if #(
    parameter int unsigned SW_W   = 8,
    parameter int unsigned LANE_W = 2,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DEPTH  = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [SW_W-1:0]        switch1;
    logic                   button1;
    logic                   button2;
    logic                   button3;
    logic [N_CH*LANE_W-1:0] data_read;
    logic [LANE_W-1:0]      data_write;
    logic [N_CH-1:0]        valid_read;
    logic                   valid_write;
    logic                   busy;
    logic [CW-1:0]          fifo_count;
    logic                   overflow;
    logic                   bad_ch;

    modport master (
        output switch1, button1, button2, button3,
        input  data_read, data_write, valid_read, valid_write, busy, fifo_count, overflow, bad_ch
    );

    modport slave (
        input  switch1, button1, button2, button3,
        output data_read, data_write, valid_read, valid_write, busy, fifo_count, overflow, bad_ch
    );
endinterface

// File: rtl/command_sequencer.sv
// command_sequencer: captures switch words into a FIFO, then serializes the whole queue MSB-first
// onto the write lane or the addressed read lane. Define CMD_PARITY_EN to append an even-parity
// symbol {zeros, ^word} after each command's data symbols.
module command_sequencer #(
    parameter int unsigned SW_W    = 8,
    parameter int unsigned LANE_W  = 2,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    command_sequencer_if.slave bus
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
`ifdef CMD_PARITY_EN
    localparam int unsigned NSYM = SW_W / LANE_W + 1;
`else
    localparam int unsigned NSYM = SW_W / LANE_W;
`endif
    localparam int unsigned SR_W = NSYM * LANE_W;
    localparam int unsigned SC_W = $clog2(NSYM + 1);
    localparam int unsigned GC_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    logic [2:0]             r_btn_q, r_rise;
    logic [SW_W-1:0]        r_sw;
    logic [SW_W-1:0]        r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]          r_count;
    state_e                 r_state;
    logic [SR_W-1:0]        r_shift;
    logic [SC_W-1:0]        r_sym_cnt;
    logic [GC_W-1:0]        r_gap_cnt;
    logic                   r_op;
    logic [CH_W-1:0]        r_ch;
    logic [N_CH*LANE_W-1:0] r_data_read;
    logic [LANE_W-1:0]      r_data_write;
    logic [N_CH-1:0]        r_valid_read;
    logic                   r_valid_write, r_busy, r_overflow, r_bad_ch;

    logic                   w_rise1, w_rise2, w_rise3;
    logic                   w_full, w_push, w_pop, w_ovf_set;
    logic [CW-1:0]          w_count_d;
    logic [SW_W-1:0]        w_head;
    logic                   w_head_op, w_head_bad;
    logic [CH_W-1:0]        w_head_ch;
    logic [SR_W-1:0]        w_load_val;
    state_e                 w_state_d;
    logic [SR_W-1:0]        w_shift_d;
    logic [SC_W-1:0]        w_sym_d;
    logic [GC_W-1:0]        w_gap_d;
    logic                   w_op_d, w_bad_d, w_emit, w_emit_op;
    logic [CH_W-1:0]        w_ch_d, w_emit_ch;
    logic [LANE_W-1:0]      w_sym;
    logic [N_CH*LANE_W-1:0] w_dr_d;
    logic [LANE_W-1:0]      w_dw_d;
    logic [N_CH-1:0]        w_vr_d;
    logic                   w_vw_d;

    assign w_rise1 = r_rise[0];
    assign w_rise2 = r_rise[1];
    assign w_rise3 = r_rise[2];

    // Abort outranks push: a button1 rise coinciding with button3 is dropped silently.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = w_rise1 && !w_rise3 && (!w_full || w_pop);
    assign w_ovf_set = w_rise1 && !w_rise3 && w_full && !w_pop;
    assign w_count_d = (w_push && !w_pop) ? r_count + CW'(1) :
                       (!w_push && w_pop) ? r_count - CW'(1) : r_count;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_op  = w_head[SW_W-1];
    assign w_head_ch  = w_head[SW_W-2 -: CH_W];
    assign w_head_bad = !w_head_op && (32'(w_head_ch) >= N_CH);
`ifdef CMD_PARITY_EN
    assign w_load_val = {w_head, LANE_W'(^w_head)};
`else
    assign w_load_val = w_head;
`endif

    // Register the buttons and switches; each rise becomes a one-cycle pulse with its word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_q <= '0;
            r_rise  <= '0;
            r_sw    <= '0;
        end else begin
            r_btn_q <= {bus.button3, bus.button2, bus.button1};
            r_rise  <= {bus.button3, bus.button2, bus.button1} & ~r_btn_q;
            r_sw    <= bus.switch1;
        end
    end

    // Command FIFO with flush on abort and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_rise3) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_sw;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_d;
            if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

    // Sequencer next state; symbols are emitted on the transition so the lanes stay registered.
    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_sym_d   = r_sym_cnt;
        w_gap_d   = r_gap_cnt;
        w_op_d    = r_op;
        w_ch_d    = r_ch;
        w_bad_d   = r_bad_ch;
        w_pop     = 1'b0;
        w_emit    = 1'b0;
        w_emit_op = r_op;
        w_emit_ch = r_ch;
        w_sym     = r_shift[SR_W-1 -: LANE_W];
        if (w_rise3) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle: if (w_rise2 && r_count != '0) w_state_d = StLoad;
                StLoad: begin
                    w_pop  = 1'b1;
                    w_op_d = w_head_op;
                    w_ch_d = w_head_ch;
                    if (w_head_bad) begin
                        w_bad_d   = 1'b1;
                        w_state_d = StGap;
                        w_gap_d   = GC_W'(GAP_CYC - 1);
                    end else begin
                        w_state_d = StShift;
                        w_emit    = 1'b1;
                        w_emit_op = w_head_op;
                        w_emit_ch = w_head_ch;
                        w_sym     = w_load_val[SR_W-1 -: LANE_W];
                        w_shift_d = w_load_val << LANE_W;
                        w_sym_d   = SC_W'(NSYM - 1);
                    end
                end
                StShift: begin
                    if (r_sym_cnt == '0) begin
                        w_state_d = StGap;
                        w_gap_d   = GC_W'(GAP_CYC - 1);
                    end else begin
                        w_emit    = 1'b1;
                        w_shift_d = r_shift << LANE_W;
                        w_sym_d   = r_sym_cnt - SC_W'(1);
                    end
                end
                StGap: begin
                    if (r_gap_cnt == '0) w_state_d = (r_count != '0) ? StLoad : StIdle;
                    else w_gap_d = r_gap_cnt - GC_W'(1);
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Route the emitted symbol to exactly one lane; every other lane stays 0.
    always_comb begin
        w_dr_d = '0;
        w_dw_d = '0;
        w_vr_d = '0;
        w_vw_d = 1'b0;
        if (w_emit) begin
            if (w_emit_op) begin
                w_dw_d = w_sym;
                w_vw_d = 1'b1;
            end else begin
                for (int c = 0; c < int'(N_CH); c++) begin
                    if (w_emit_ch == CH_W'(c)) begin
                        w_dr_d[c*LANE_W +: LANE_W] = w_sym;
                        w_vr_d[c]                  = 1'b1;
                    end
                end
            end
        end
    end

    // Sequencer state, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_shift       <= '0;
            r_sym_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_op          <= 1'b0;
            r_ch          <= '0;
            r_bad_ch      <= 1'b0;
            r_busy        <= 1'b0;
            r_data_read   <= '0;
            r_data_write  <= '0;
            r_valid_read  <= '0;
            r_valid_write <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_shift       <= w_shift_d;
            r_sym_cnt     <= w_sym_d;
            r_gap_cnt     <= w_gap_d;
            r_op          <= w_op_d;
            r_ch          <= w_ch_d;
            r_bad_ch      <= w_bad_d;
            r_busy        <= (w_state_d != StIdle);
            r_data_read   <= w_dr_d;
            r_data_write  <= w_dw_d;
            r_valid_read  <= w_vr_d;
            r_valid_write <= w_vw_d;
        end
    end

    assign bus.data_read   = r_data_read;
    assign bus.data_write  = r_data_write;
    assign bus.valid_read  = r_valid_read;
    assign bus.valid_write = r_valid_write;
    assign bus.busy        = r_busy;
    assign bus.fifo_count  = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.bad_ch      = r_bad_ch;
endmodule

// File: tb/tb_command_sequencer.sv
// tb_command_sequencer: randomized bench with a queue/timeline model of command_sequencer.
// Honours CMD_PARITY_EN when the build defines it.
module tb_command_sequencer;
    localparam int unsigned SW_W    = 8;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned N_CH    = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned GAP_CYC = 2;
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef CMD_PARITY_EN
    localparam int NSYM = SW_W / LANE_W + 1;
`else
    localparam int NSYM = SW_W / LANE_W;
`endif
    localparam int OUT_W = 2 + LANE_W + N_CH + N_CH * LANE_W;
    localparam int MAXC  = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [SW_W-1:0]  q_model [$];
    logic [OUT_W-1:0] exp_log [MAXC];
    logic [OUT_W-1:0] obs_log [MAXC];
    int               exp_len;

    always #5 clk = ~clk;

    command_sequencer_if #(.SW_W(SW_W), .LANE_W(LANE_W), .N_CH(N_CH), .DEPTH(DEPTH)) bus2 ();
    command_sequencer_if #(.SW_W(SW_W), .LANE_W(LANE_W), .N_CH(3), .DEPTH(DEPTH)) bus3 ();

    command_sequencer #(
        .SW_W(SW_W), .LANE_W(LANE_W), .N_CH(N_CH), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    command_sequencer #(
        .SW_W(SW_W), .LANE_W(LANE_W), .N_CH(3), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    // j-th symbol of a command: MSB-first slices, then the parity symbol if enabled.
    function automatic logic [LANE_W-1:0] exp_sym(input logic [SW_W-1:0] w, input int j);
        logic [SW_W-1:0] t;
        if (j < int'(SW_W / LANE_W)) begin
            t = w >> (SW_W - (j + 1) * LANE_W);
            return t[LANE_W-1:0];
        end
        return LANE_W'(^w);
    endfunction

    // Output vector {valid_write, data_write, valid_read, data_read, busy} while a symbol shows.
    function automatic logic [OUT_W-1:0] exp_out(input logic [SW_W-1:0] w,
                                                 input logic [LANE_W-1:0] s);
        logic [N_CH-1:0]        vr;
        logic [N_CH*LANE_W-1:0] dr;
        int                     ch;
        if (w[SW_W-1]) return {1'b1, s, {N_CH{1'b0}}, {(N_CH * LANE_W){1'b0}}, 1'b1};
        ch = int'(w[SW_W-2 -: CH_W]);
        vr = '0;
        dr = '0;
        vr[ch] = 1'b1;
        dr[ch*LANE_W +: LANE_W] = s;
        return {1'b0, {LANE_W{1'b0}}, vr, dr, 1'b1};
    endfunction

    // Timeline of a full drain: LOAD, NSYM symbols, GAP_CYC idle, repeat; then idle.
    task automatic build_expect();
        int l, last;
        for (int k = 0; k < MAXC; k++) exp_log[k] = '0;
        l = 1;
        foreach (q_model[i]) begin
            for (int j = 0; j < NSYM; j++) exp_log[l+1+j] = exp_out(q_model[i], exp_sym(q_model[i], j));
            last = l + NSYM + int'(GAP_CYC);
            for (int k = l; k <= last; k++) exp_log[k][0] = 1'b1;
            l = last + 1;
        end
        exp_len = l + 2;
        q_model.delete();
    endtask

    task automatic run_collect();
        @(negedge clk) bus2.button2 = 1'b1;
        @(negedge clk) bus2.button2 = 1'b0;
        for (int k = 1; k < exp_len; k++) begin
            @(negedge clk);
            obs_log[k] = {bus2.valid_write, bus2.data_write, bus2.valid_read, bus2.data_read,
                          bus2.busy};
        end
    endtask

    task automatic push_word(input logic [SW_W-1:0] w);
        @(negedge clk);
        bus2.switch1 = w;
        bus2.button1 = 1'b1;
        @(negedge clk) bus2.button1 = 1'b0;
        @(negedge clk);
        if (q_model.size() < DEPTH) q_model.push_back(w);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus2.data_read, bus2.data_write, bus2.valid_read, bus2.valid_write, bus2.busy,
             bus2.fifo_count, bus2.overflow, bus2.bad_ch} !== '0) begin
            errors++;
            $display("FAIL reset_dut2 got %h required 0", {bus2.data_read, bus2.data_write,
                     bus2.valid_read, bus2.valid_write, bus2.busy, bus2.fifo_count,
                     bus2.overflow, bus2.bad_ch});
        end
        checks++;
        if ({bus3.data_read, bus3.data_write, bus3.valid_read, bus3.valid_write, bus3.busy,
             bus3.fifo_count, bus3.overflow, bus3.bad_ch} !== '0) begin
            errors++;
            $display("FAIL reset_dut3 got nonzero outputs required 0");
        end
    endtask

    task automatic test_single_write();
        push_word(8'b10101010);
        checks++;
        if (bus2.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL single_count got %0d required 1", bus2.fifo_count);
        end
        build_expect();
        run_collect();
        for (int k = 1; k < exp_len; k++) begin
            checks++;
            if (obs_log[k] !== exp_log[k]) begin
                errors++;
                $display("FAIL single_write cyc %0d got %h required %h", k, obs_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        push_word(8'b01100010);
        push_word(8'b11100010);
        push_word(8'b10000000);
        checks++;
        if (bus2.fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL b2b_count got %0d required 3", bus2.fifo_count);
        end
        build_expect();
        run_collect();
        for (int k = 1; k < exp_len; k++) begin
            checks++;
            if (obs_log[k] !== exp_log[k]) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %h required %h", k, obs_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_held_button();
        logic [SW_W-1:0] w;
        w = SW_W'($urandom);
        @(negedge clk);
        bus2.switch1 = w;
        bus2.button1 = 1'b1;
        repeat (3) @(negedge clk) bus2.switch1 = SW_W'($urandom);
        bus2.button1 = 1'b0;
        @(negedge clk);
        q_model.push_back(w);
        checks++;
        if (bus2.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL held_count got %0d required 1", bus2.fifo_count);
        end
        build_expect();
        run_collect();
        for (int k = 1; k < exp_len; k++) begin
            checks++;
            if (obs_log[k] !== exp_log[k]) begin
                errors++;
                $display("FAIL held_run cyc %0d got %h required %h", k, obs_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push_word(SW_W'($urandom));
            checks++;
            if (int'(bus2.fifo_count) !== n) begin
                errors++;
                $display("FAIL rand_count r%0d got %0d required %0d", r, bus2.fifo_count, n);
            end
            build_expect();
            run_collect();
            for (int k = 1; k < exp_len; k++) begin
                checks++;
                if (obs_log[k] !== exp_log[k]) begin
                    errors++;
                    $display("FAIL rand_run r%0d cyc %0d got %h required %h", r, k, obs_log[k],
                             exp_log[k]);
                end
            end
        end
    endtask

    task automatic test_abort_priority();
        push_word(SW_W'($urandom));
        @(negedge clk);
        bus2.switch1 = SW_W'($urandom);
        bus2.button1 = 1'b1;
        bus2.button3 = 1'b1;
        @(negedge clk);
        bus2.button1 = 1'b0;
        bus2.button3 = 1'b0;
        @(negedge clk);
        q_model.delete();
        checks++;
        if (bus2.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL prio_count got %0d required 0", bus2.fifo_count);
        end
        checks++;
        if (bus2.overflow !== 1'b0) begin
            errors++;
            $display("FAIL prio_overflow got %b required 0", bus2.overflow);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) push_word(SW_W'($urandom));
        checks++;
        if (bus2.fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_count got %0d required 4", bus2.fifo_count);
        end
        checks++;
        if (bus2.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got %b required 1", bus2.overflow);
        end
        build_expect();
        run_collect();
        for (int k = 1; k < exp_len; k++) begin
            checks++;
            if (obs_log[k] !== exp_log[k]) begin
                errors++;
                $display("FAIL ovf_run cyc %0d got %h required %h", k, obs_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_bad_ch();
        logic exp_busy, exp_bad;
        @(negedge clk);
        bus3.switch1 = 8'b01100000;
        bus3.button1 = 1'b1;
        @(negedge clk) bus3.button1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus3.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL badch_count got %0d required 1", bus3.fifo_count);
        end
        @(negedge clk) bus3.button2 = 1'b1;
        @(negedge clk) bus3.button2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_busy = (k <= 1 + int'(GAP_CYC));
            exp_bad  = (k >= 2);
            checks++;
            if ({bus3.valid_write, bus3.data_write, bus3.valid_read, bus3.data_read, bus3.busy,
                 bus3.bad_ch} !== {1'b0, {LANE_W{1'b0}}, 3'b000, {(3 * LANE_W){1'b0}}, exp_busy,
                 exp_bad}) begin
                errors++;
                $display("FAIL badch cyc %0d got vw%b vr%b busy%b bad%b required busy%b bad%b",
                         k, bus3.valid_write, bus3.valid_read, bus3.busy, bus3.bad_ch, exp_busy,
                         exp_bad);
            end
        end
    endtask

    task automatic test_abort();
        push_word(SW_W'($urandom));
        push_word(SW_W'($urandom));
        q_model.delete();
        @(negedge clk) bus2.button2 = 1'b1;
        @(negedge clk) bus2.button2 = 1'b0;
        repeat (3) @(negedge clk);
        bus2.button3 = 1'b1;
        @(negedge clk) bus2.button3 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus2.valid_write, bus2.data_write, bus2.valid_read, bus2.data_read, bus2.busy,
             bus2.fifo_count} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got vw%b dw%b vr%b dr%b busy%b cnt%0d required 0",
                     bus2.valid_write, bus2.data_write, bus2.valid_read, bus2.data_read,
                     bus2.busy, bus2.fifo_count);
        end
        checks++;
        if (bus2.overflow !== 1'b1) begin
            errors++;
            $display("FAIL abort_keeps_overflow got %b required 1", bus2.overflow);
        end
        @(negedge clk) bus2.button2 = 1'b1;
        @(negedge clk) bus2.button2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus2.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_run_ignored cyc %0d got busy %b required 0", k, bus2.busy);
            end
        end
    endtask

    task automatic test_async_reset();
        push_word(8'b11110000);
        q_model.delete();
        @(negedge clk) bus2.button2 = 1'b1;
        @(negedge clk) bus2.button2 = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus2.data_read, bus2.data_write, bus2.valid_read, bus2.valid_write, bus2.busy,
             bus2.fifo_count, bus2.overflow, bus2.bad_ch} !== '0) begin
            errors++;
            $display("FAIL async_reset got vw%b dw%b busy%b cnt%0d ovf%b required 0",
                     bus2.valid_write, bus2.data_write, bus2.busy, bus2.fifo_count,
                     bus2.overflow);
        end
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus2.switch1 = '0;
        bus2.button1 = 1'b0;
        bus2.button2 = 1'b0;
        bus2.button3 = 1'b0;
        bus3.switch1 = '0;
        bus3.button1 = 1'b0;
        bus3.button2 = 1'b0;
        bus3.button3 = 1'b0;
        #12;
        test_reset();
        @(negedge clk) reset = 1'b0;
        test_single_write();
        test_back_to_back();
        test_held_button();
        test_random();
        test_abort_priority();
        test_overflow();
        test_bad_ch();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
